eth_capture_ring_ctl: RTL and testbench

Sequences the Ethernet capture path and manages its 1024-slot packet ring in host memory, all in the AXI `clk` domain. It gates the capture enable, issues the capture FIFO reset on start, tracks producer/consumer slot indices, and pauses capture before the ring overwrites unconsumed packets. It also generates a coalesced host interrupt. It sits between the host register block and the capture path's `enable`/`reset` inputs and DMA status-burst completion.

---
 rtl/eth_capture_ring_ctl_if.sv | 39 +++
 rtl/eth_capture_ring_ctl.sv | 178 +++++++++++++++++
 tb/tb_eth_capture_ring_ctl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_capture_ring_ctl_if.sv
// Host/capture-path signal bundle for eth_capture_ring_ctl.
// master drives the controls; slave is the ring controller.
interface eth_capture_ring_ctl_if;
    localparam int unsigned IDX_W = 10;
    localparam int unsigned PEND_W = 11;
    localparam int unsigned TMO_W = 16;

    logic              start;
    logic              stop;
    logic              cons_wr;
    logic [IDX_W-1:0]  cons_idx;
    logic [IDX_W-1:0]  irq_thresh;
    logic [TMO_W-1:0]  irq_timeout;
    logic              irq_ack;
    logic              pkt_done;
    logic              dma_busy;
    logic              cap_enable;
    logic              cap_reset;
    logic [IDX_W-1:0]  prod_idx;
    logic [PEND_W-1:0] pending;
    logic [2:0]        state;
    logic              overrun;
    logic              cons_err;
    logic              irq;

    modport master (
        output start, stop, cons_wr, cons_idx, irq_thresh, irq_timeout,
               irq_ack, pkt_done, dma_busy,
        input  cap_enable, cap_reset, prod_idx, pending, state,
               overrun, cons_err, irq
    );

    modport slave (
        input  start, stop, cons_wr, cons_idx, irq_thresh, irq_timeout,
               irq_ack, pkt_done, dma_busy,
        output cap_enable, cap_reset, prod_idx, pending, state,
               overrun, cons_err, irq
    );
endinterface

// File: rtl/eth_capture_ring_ctl.sv
// Capture-path sequencer and 1024-slot packet ring tracker with coalesced irq.
// Optional irq coalescing timeout: define ETH_CAPTURE_IRQ_TIMEOUT_EN.
module eth_capture_ring_ctl #(
    parameter int unsigned HEADROOM     = 4,
    parameter int unsigned RESUME_LEVEL = 512,
    parameter int unsigned FLUSH_CYCLES = 16,
    parameter int unsigned DRAIN_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    eth_capture_ring_ctl_if.slave bus
);
    localparam int unsigned SLOTS  = 1024;
    localparam int unsigned IDX_W  = 10;
    localparam int unsigned PEND_W = 11;
    localparam int unsigned SUM_W  = 12;
    localparam int unsigned CNT_W  = 8;

    localparam logic [PEND_W-1:0] FULL       = PEND_W'(SLOTS);
    localparam logic [PEND_W-1:0] PAUSE_LVL  = PEND_W'(SLOTS - HEADROOM);
    localparam logic [PEND_W-1:0] RESUME_LVL = PEND_W'(RESUME_LEVEL);
    localparam logic [CNT_W-1:0]  FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   flush_cnt_q, drain_cnt_q;
    logic               stop_pend_q;
    logic               cap_enable_q, cap_reset_q, cap_enable_d, cap_reset_d;
    logic               enter_flush, enter_drain;
    logic [IDX_W-1:0]   prod_q, cons_q, irq_cnt_q;
    logic [PEND_W-1:0]  pend_q;
    logic               overrun_q, cons_err_q, irq_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; stop outranks start and the pause/resume thresholds
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (bus.start && !bus.stop) state_d = ST_FLUSH;
            ST_FLUSH: if (flush_cnt_q == FLUSH_LAST)
                          state_d = (stop_pend_q || bus.stop) ? ST_DRAIN : ST_RUN;
            ST_RUN:   if (bus.stop)                state_d = ST_DRAIN;
                      else if (pend_q >= PAUSE_LVL) state_d = ST_PAUSE;
            ST_PAUSE: if (bus.stop)                 state_d = ST_DRAIN;
                      else if (pend_q <= RESUME_LVL) state_d = ST_RUN;
            ST_DRAIN: if (!bus.dma_busy && drain_cnt_q == DRAIN_LAST) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode from the next state so outputs flip on the transition edge
    always_comb begin
        cap_enable_d = 1'b0;
        cap_reset_d  = 1'b0;
        enter_flush  = 1'b0;
        enter_drain  = 1'b0;
        cap_enable_d = (state_d == ST_RUN);
        cap_reset_d  = (state_d == ST_FLUSH);
        enter_flush  = (state_q != ST_FLUSH) && (state_d == ST_FLUSH);
        enter_drain  = (state_q != ST_DRAIN) && (state_d == ST_DRAIN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_enable_q <= 1'b0;
            cap_reset_q  <= 1'b0;
            flush_cnt_q  <= '0;
            drain_cnt_q  <= '0;
            stop_pend_q  <= 1'b0;
        end else begin
            cap_enable_q <= cap_enable_d;
            cap_reset_q  <= cap_reset_d;
            if (enter_flush)              flush_cnt_q <= '0;
            else if (state_q == ST_FLUSH) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            if (enter_drain || bus.dma_busy) drain_cnt_q <= '0;
            else if (state_q == ST_DRAIN)    drain_cnt_q <= drain_cnt_q + CNT_W'(1);
            if (enter_flush)                         stop_pend_q <= 1'b0;
            else if (state_q == ST_FLUSH && bus.stop) stop_pend_q <= 1'b1;
        end
    end

    // Ring accounting; consumer delta is checked against pre-increment pending
    logic              pkt, cons_ok;
    logic [IDX_W-1:0]  delta, prod_d, thr, irq_cnt_d;
    logic [SUM_W-1:0]  sum;
    logic [PEND_W-1:0] pend_d;
    logic              irq_d, timer_hit;

    always_comb begin
        pkt     = bus.pkt_done && (state_q == ST_RUN || state_q == ST_PAUSE ||
                                   state_q == ST_DRAIN);
        delta   = IDX_W'(bus.cons_idx - cons_q);
        cons_ok = bus.cons_wr && (PEND_W'(delta) <= pend_q);
        sum     = SUM_W'(pend_q) + SUM_W'(pkt) - (cons_ok ? SUM_W'(delta) : SUM_W'(0));
        pend_d  = (sum > SUM_W'(FULL)) ? FULL : sum[PEND_W-1:0];
        prod_d  = pkt ? prod_q + IDX_W'(1) : prod_q;
        thr     = (bus.irq_thresh == '0) ? IDX_W'(1) : bus.irq_thresh;
        if (bus.irq_ack)  irq_cnt_d = pkt ? IDX_W'(1) : '0;
        else if (pkt)     irq_cnt_d = (irq_cnt_q == '1) ? irq_cnt_q : irq_cnt_q + IDX_W'(1);
        else              irq_cnt_d = irq_cnt_q;
        irq_d = bus.irq_ack ? 1'b0 : (irq_q || (pkt && irq_cnt_d >= thr) || timer_hit);
    end

`ifdef ETH_CAPTURE_IRQ_TIMEOUT_EN
    localparam int unsigned TMO_W = 16;
    logic [TMO_W-1:0] timer_q, timer_d;

    // Timer runs only while packets are waiting without an interrupt raised
    always_comb begin
        timer_d   = '0;
        timer_hit = 1'b0;
        if (irq_cnt_q != '0 && !irq_q && !pkt && !bus.irq_ack) begin
            timer_d   = timer_q + TMO_W'(1);
            timer_hit = (bus.irq_timeout != '0) && (timer_d == bus.irq_timeout);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)            timer_q <= '0;
        else if (enter_flush) timer_q <= '0;
        else                  timer_q <= timer_d;
    end
`else
    logic [15:0] irq_timeout_unused;
    assign irq_timeout_unused = bus.irq_timeout;
    assign timer_hit          = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_q     <= '0;
            cons_q     <= '0;
            pend_q     <= '0;
            overrun_q  <= 1'b0;
            cons_err_q <= 1'b0;
            irq_q      <= 1'b0;
            irq_cnt_q  <= '0;
        end else if (enter_flush) begin
            prod_q     <= '0;
            cons_q     <= '0;
            pend_q     <= '0;
            overrun_q  <= 1'b0;
            cons_err_q <= 1'b0;
            irq_q      <= 1'b0;
            irq_cnt_q  <= '0;
        end else begin
            prod_q     <= prod_d;
            cons_q     <= cons_ok ? bus.cons_idx : cons_q;
            pend_q     <= pend_d;
            overrun_q  <= overrun_q || (pkt && pend_q == FULL);
            cons_err_q <= cons_err_q || (bus.cons_wr && !cons_ok);
            irq_q      <= irq_d;
            irq_cnt_q  <= irq_cnt_d;
        end
    end

    assign bus.cap_enable = cap_enable_q;
    assign bus.cap_reset  = cap_reset_q;
    assign bus.prod_idx   = prod_q;
    assign bus.pending    = pend_q;
    assign bus.state      = 3'(state_q);
    assign bus.overrun    = overrun_q;
    assign bus.cons_err   = cons_err_q;
    assign bus.irq        = irq_q;
endmodule

// File: tb/tb_eth_capture_ring_ctl.sv
// Self-checking bench for eth_capture_ring_ctl: vector table with scoreboard
// plus hand-written pause, overrun, drain and flush sequences.
module tb_eth_capture_ring_ctl;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    eth_capture_ring_ctl_if bus ();

    eth_capture_ring_ctl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start, stop, cons_wr;
        logic [9:0] cons_idx;
        logic       pkt, ack;
        logic [10:0] e_pend;
        logic [9:0] e_prod;
        logic       e_irq, e_err;
        logic [2:0] e_state;
    } vec_t;

    typedef struct {
        logic [10:0] pend;
        logic [9:0]  prod;
        logic        irq, err;
        logic [2:0]  state;
    } exp_t;

    vec_t tbl[21];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses();
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.cons_wr  = 1'b0;
        bus.pkt_done = 1'b0;
        bus.irq_ack  = 1'b0;
    endtask

    task automatic pkts(input int n);
        bus.pkt_done = 1'b1;
        repeat (n) tick();
        bus.pkt_done = 1'b0;
    endtask

    task automatic cons(input logic [9:0] idx);
        bus.cons_wr  = 1'b1;
        bus.cons_idx = idx;
        tick();
        bus.cons_wr  = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int lim, input string name);
        int n = 0;
        while (bus.state !== s && n < lim) begin
            tick();
            n++;
        end
        check(name, 32'(bus.state), 32'(s));
    endtask

    task automatic restart();
        bus.dma_busy = 1'b0;
        wait_state(3'd0, 200, "to_idle");
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_state(3'd2, 40, "to_run");
    endtask

    function automatic vec_t mk(input logic st, input logic sp, input logic cw,
                                input int ci, input logic pk, input logic ak,
                                input int pend, input int prod, input logic irq,
                                input logic err, input int state);
        vec_t v;
        v.start = st; v.stop = sp; v.cons_wr = cw; v.cons_idx = 10'(ci);
        v.pkt = pk; v.ack = ak;
        v.e_pend = 11'(pend); v.e_prod = 10'(prod);
        v.e_irq = irq; v.e_err = err; v.e_state = 3'(state);
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        exp_t e;
        bus.start    = v.start;
        bus.stop     = v.stop;
        bus.cons_wr  = v.cons_wr;
        bus.cons_idx = v.cons_idx;
        bus.pkt_done = v.pkt;
        bus.irq_ack  = v.ack;
        e.pend = v.e_pend; e.prod = v.e_prod; e.irq = v.e_irq;
        e.err = v.e_err; e.state = v.e_state;
        sb.push_back(e);
        tick();
        clear_pulses();
        e = sb.pop_front();
        check("vec_pending",  32'(bus.pending),  32'(e.pend));
        check("vec_prod_idx", 32'(bus.prod_idx), 32'(e.prod));
        check("vec_irq",      32'(bus.irq),      32'(e.irq));
        check("vec_cons_err", 32'(bus.cons_err), 32'(e.err));
        check("vec_state",    32'(bus.state),    32'(e.state));
    endtask

    initial begin
        // start stop cw idx pkt ack | pend prod irq err state (thresh 4)
        tbl[0]  = mk(0, 0, 0,  0, 1, 0,  1,  1, 0, 0, 2);
        tbl[1]  = mk(0, 0, 0,  0, 1, 0,  2,  2, 0, 0, 2);
        tbl[2]  = mk(0, 0, 0,  0, 1, 0,  3,  3, 0, 0, 2);
        tbl[3]  = mk(0, 0, 0,  0, 1, 0,  4,  4, 1, 0, 2);
        tbl[4]  = mk(0, 0, 0,  0, 1, 1,  5,  5, 0, 0, 2);
        tbl[5]  = mk(0, 0, 0,  0, 1, 0,  6,  6, 0, 0, 2);
        tbl[6]  = mk(0, 0, 1,  1, 0, 0,  5,  6, 0, 0, 2);
        tbl[7]  = mk(0, 0, 0,  0, 1, 0,  6,  7, 0, 0, 2);
        tbl[8]  = mk(0, 0, 0,  0, 1, 0,  7,  8, 1, 0, 2);
        tbl[9]  = mk(0, 0, 0,  0, 0, 1,  7,  8, 0, 0, 2);
        tbl[10] = mk(0, 0, 1,  9, 0, 0,  7,  8, 0, 1, 2);
        tbl[11] = mk(0, 0, 1,  8, 1, 0,  1,  9, 0, 1, 2);
        tbl[12] = mk(0, 0, 0,  0, 1, 0,  2, 10, 0, 1, 2);
        tbl[13] = mk(0, 0, 0,  0, 1, 0,  3, 11, 0, 1, 2);
        tbl[14] = mk(0, 0, 0,  0, 1, 0,  4, 12, 1, 1, 2);
        tbl[15] = mk(0, 0, 0,  0, 1, 0,  5, 13, 1, 1, 2);
        tbl[16] = mk(0, 0, 1, 14, 0, 0,  5, 13, 1, 1, 2);
        tbl[17] = mk(0, 0, 1, 11, 1, 0,  3, 14, 1, 1, 2);
        tbl[18] = mk(0, 0, 0,  0, 0, 1,  3, 14, 0, 1, 2);
        tbl[19] = mk(0, 0, 1, 14, 0, 0,  0, 14, 0, 1, 2);
        tbl[20] = mk(1, 0, 1, 14, 0, 0,  0, 14, 0, 1, 2);

        reset = 1'b1;
        clear_pulses();
        bus.cons_idx    = '0;
        bus.irq_thresh  = 10'd4;
        bus.irq_timeout = '0;
        bus.dma_busy    = 1'b0;
        repeat (3) tick();
        check("rst_state",      32'(bus.state),      0);
        check("rst_cap_enable", 32'(bus.cap_enable), 0);
        check("rst_cap_reset",  32'(bus.cap_reset),  0);
        check("rst_pending",    32'(bus.pending),    0);
        check("rst_prod_idx",   32'(bus.prod_idx),   0);
        check("rst_flags",      32'({bus.overrun, bus.cons_err, bus.irq}), 0);
        reset = 1'b0;
        tick();

        // Flush length and entry into RUN
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("flush_state", 32'(bus.state), 1);
        begin
            int n = 0;
            while (bus.cap_reset === 1'b1 && n < 100) begin
                n++;
                tick();
            end
            check("flush_len", 32'(n), 16);
        end
        check("run_state",      32'(bus.state),      2);
        check("run_cap_enable", 32'(bus.cap_enable), 1);
        check("run_pending",    32'(bus.pending),    0);

        for (int i = 0; i < 21; i++) run_vec(tbl[i]);
        check("sb_empty", 32'(sb.size()), 0);

        // Pause one cycle after pending hits 1020, resume after consumption
        pkts(1020);
        check("pause_pend",    32'(bus.pending), 1020);
        check("pause_latency", 32'(bus.state),   2);
        tick();
        check("pause_state",   32'(bus.state),      3);
        check("pause_cap_en",  32'(bus.cap_enable), 0);
        cons(10'(14 + 600));
        check("resume_pend",   32'(bus.pending),  420);
        check("resume_prod",   32'(bus.prod_idx), 10);
        tick();
        check("resume_state",  32'(bus.state),      2);
        check("resume_cap_en", 32'(bus.cap_enable), 1);

        // Drain needs 64 consecutive idle dma cycles
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check("drain_state", 32'(bus.state), 4);
        bus.dma_busy = 1'b0; repeat (30) tick();
        bus.dma_busy = 1'b1; tick();
        bus.dma_busy = 1'b0; repeat (63) tick();
        check("drain_hold", 32'(bus.state), 4);
        tick();
        check("drain_exit", 32'(bus.state), 0);

        // start with stop in IDLE: stop wins
        bus.start = 1'b1; bus.stop = 1'b1;
        tick();
        clear_pulses();
        check("idle_start_stop", 32'(bus.state), 0);

        restart();
        check("clr_cons_err", 32'(bus.cons_err), 0);
        check("clr_pending",  32'(bus.pending),  0);
        check("clr_prod",     32'(bus.prod_idx), 0);

        // Saturation and overrun, prod_idx wraps
        pkts(1024);
        check("full_pend",    32'(bus.pending),  1024);
        check("full_overrun", 32'(bus.overrun),  0);
        check("full_prod",    32'(bus.prod_idx), 0);
        pkts(1);
        check("ovr_flag",  32'(bus.overrun),  1);
        check("ovr_pend",  32'(bus.pending),  1024);
        check("ovr_prod",  32'(bus.prod_idx), 1);
        check("ovr_state", 32'(bus.state),    3);
        cons(10'd1);
        check("cons_full1", 32'(bus.pending), 1023);
        cons(10'd1023);
        check("cons_full2", 32'(bus.pending), 1);
        tick();
        check("ovr_resume", 32'(bus.state), 2);

        // start with stop in RUN goes to DRAIN
        bus.start = 1'b1; bus.stop = 1'b1;
        tick();
        clear_pulses();
        check("run_start_stop", 32'(bus.state),      4);
        check("drain_cap_en",   32'(bus.cap_enable), 0);

        // stop during FLUSH honoured when the flush ends
        wait_state(3'd0, 200, "idle_again");
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        repeat (3) tick();
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
        check("flush_hold", 32'(bus.state), 1);
        begin
            int n = 0;
            while (bus.state === 3'd1 && n < 50) begin
                tick();
                n++;
            end
        end
        check("flush_stop_state", 32'(bus.state),     4);
        check("flush_stop_rst",   32'(bus.cap_reset), 0);

        restart();
`ifdef ETH_CAPTURE_IRQ_TIMEOUT_EN
        bus.irq_thresh  = 10'd10;
        bus.irq_timeout = 16'd100;
        pkts(1);
        begin
            int n = 0;
            while (bus.irq !== 1'b1 && n < 300) begin
                tick();
                n++;
            end
            check("irq_timeout", 32'(n), 100);
        end
`endif

        // Async reset drops the capture controls without a clock edge
        check("pre_rst_cap_en", 32'(bus.cap_enable), 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_cap_en", 32'(bus.cap_enable), 0);
        check("async_state",  32'(bus.state),      0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
